// File: rtl/crypto_block_seq.sv
// rtl/crypto_block_seq.sv - one-block-in-flight sequencer between a block stream and a crypto engine
//
// Purpose: accepts plaintext blocks, launches the external crypto engine once per
// block, waits for its result and presents it on the output stream. Key and
// algorithm are latched only at the first block of each packet.
// Optional feature macro: CRYPTO_TIMEOUT_EN (engine wait timeout, sticky err_timeout).
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   cfg_algo_sel, cfg_key               algorithm (0=AES, 1=SM4) and key, sampled at packet start
//   s_valid/s_ready/s_data/s_last       input block stream
//   m_valid/m_ready/m_data/m_last       output block stream
//   eng_start, eng_algo_sel/key/din     engine launch pulse and operands
//   eng_busy, eng_done, eng_dout        engine status and result
//   blk_cnt                             completed output blocks (wrapping)
//   err_timeout                         sticky engine timeout flag
module crypto_block_seq #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_algo_sel,
  input  logic [127:0] cfg_key,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic         eng_start,
  output logic         eng_algo_sel,
  output logic [127:0] eng_key,
  output logic [127:0] eng_din,
  input  logic         eng_busy,
  input  logic         eng_done,
  input  logic [127:0] eng_dout,
  output logic [31:0]  blk_cnt,
  output logic         err_timeout
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, OUT} state_t;

  state_t state, state_nxt;
  logic   pkt_start;
  logic   tmo_hit;

`ifdef CRYPTO_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counter holds the number of WAIT cycles already spent, so the compare
  // against TIMEOUT_CYCLES-1 fires on the TIMEOUT_CYCLES-th WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == LAUNCH) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // A result arriving on the deadline cycle takes priority over the abort.
  assign tmo_hit = (state == WAIT) && !eng_done && (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (tmo_hit) begin
      err_timeout <= 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    eng_start = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset; also waits for a still-busy engine left
        // over from an abandoned block.
        s_ready = rst_n && !eng_busy;
        if (s_valid && rst_n && !eng_busy) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        eng_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (eng_done || tmo_hit) state_nxt = OUT;
      end
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_start    <= 1'b1;
      eng_din      <= '0;
      eng_key      <= '0;
      eng_algo_sel <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      blk_cnt      <= '0;
    end else begin
      if (state == IDLE && s_valid && s_ready) begin
        eng_din   <= s_data;
        m_last    <= s_last;
        pkt_start <= s_last;
        if (pkt_start) begin
          eng_algo_sel <= cfg_algo_sel;
          eng_key      <= cfg_key;
        end
      end
      if (state == WAIT) begin
        if (eng_done) begin
          m_data <= eng_dout;
        end else if (tmo_hit) begin
          m_data <= '0;
        end
      end
      if (m_valid && m_ready) begin
        blk_cnt <= blk_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_crypto_block_seq.sv
// tb/tb_crypto_block_seq.sv - self-checking bench for crypto_block_seq
module tb_crypto_block_seq;

`ifdef CRYPTO_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 256;
`endif

  localparam logic [127:0] SM4K = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] SM4C = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] AESK = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] AESD = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] AESC = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_algo_sel;
  logic [127:0] cfg_key;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         eng_start;
  logic         eng_algo_sel;
  logic [127:0] eng_key;
  logic [127:0] eng_din;
  logic         eng_busy = 1'b0;
  logic         eng_done = 1'b0;
  logic [127:0] eng_dout = '0;
  logic [31:0]  blk_cnt;
  logic         err_timeout;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  crypto_block_seq #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_algo_sel(cfg_algo_sel), .cfg_key(cfg_key),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .eng_start(eng_start), .eng_algo_sel(eng_algo_sel), .eng_key(eng_key), .eng_din(eng_din),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_dout(eng_dout),
    .blk_cnt(blk_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Engine model: known vectors give the published ciphertext, anything else
  // gives din^key (AES) or ~(din^key) (SM4).
  int           eng_lat = 3;
  bit           eng_hang = 0;
  int           starts = 0;
  int           op_err = 0;
  int           ecnt = 0;
  logic [127:0] cap_key, cap_din;
  logic         cap_algo;
  logic [127:0] keys_seen[$];

  function automatic logic [127:0] engine_f(input logic algo, input logic [127:0] key,
                                            input logic [127:0] din);
    if (algo && key == SM4K && din == SM4K) return SM4C;
    if (!algo && key == AESK && din == AESD) return AESC;
    return algo ? ~(din ^ key) : (din ^ key);
  endfunction

  always @(posedge clk) begin
    eng_done <= 1'b0;
    if (eng_start) begin
      starts   <= starts + 1;
      keys_seen.push_back(eng_key);
      cap_key  <= eng_key;
      cap_din  <= eng_din;
      cap_algo <= eng_algo_sel;
      eng_dout <= engine_f(eng_algo_sel, eng_key, eng_din);
      if (!eng_hang) begin
        eng_busy <= 1'b1;
        ecnt     <= eng_lat;
      end
    end else if (eng_busy) begin
      if (eng_key !== cap_key || eng_din !== cap_din || eng_algo_sel !== cap_algo)
        op_err <= op_err + 1;
      if (ecnt > 1) begin
        ecnt <= ecnt - 1;
      end else begin
        eng_done <= 1'b1;
        eng_busy <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic algo, input logic [127:0] key, input logic [127:0] data,
                      input logic last);
    int n;
    @(negedge clk);
    cfg_algo_sel = algo;
    cfg_key      = key;
    s_data       = data;
    s_last       = last;
    s_valid      = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", s_ready, 1);
    @(posedge clk);
    #1;
    check("start_latency", eng_start, 1);
    s_valid = 1'b0;
  endtask

  task automatic receive(input logic [127:0] exp_data, input logic exp_last, input int hold);
    int n;
    int st;
    bit ok;
    logic [127:0] held;
    @(negedge clk);
    m_ready = (hold == 0);
    n = 0;
    while (!m_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("m_valid_seen", m_valid, 1);
    if (hold > 0) begin
      held = m_data;
      st   = starts;
      ok   = 1;
      repeat (hold) begin
        @(negedge clk);
        if (!m_valid || m_data !== held || s_ready || starts != st) ok = 0;
      end
      check("backpressure_stable", ok, 1);
      m_ready = 1'b1;
    end
    check("m_data", m_data, exp_data);
    check("m_last", m_last, exp_last);
    @(posedge clk);
    #1;
    exp_cnt++;
    check("m_valid_drop", m_valid, 0);
    check("blk_cnt", blk_cnt, exp_cnt);
    m_ready = 1'b0;
  endtask

  typedef struct {
    logic         algo;
    logic [127:0] key;
    logic [127:0] data;
    logic         last;
    int           lat;
    logic [127:0] exp_data;
    logic         exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int n;
    int st;
    bit ok;

    vecs[0] = '{1'b1, SM4K, SM4K, 1'b1, 3, SM4C, 1'b1};
    vecs[1] = '{1'b0, AESK, AESD, 1'b1, 1, AESC, 1'b1};
    vecs[2] = '{1'b0, {128{1'b1}}, 128'h0, 1'b1, 5, {128{1'b1}}, 1'b1};
    vecs[3] = '{1'b1, 128'h0, 128'h0f, 1'b1, 2, 128'hfffffffffffffffffffffffffffffff0, 1'b1};
    vecs[4] = '{1'b0, 128'h1, 128'h3, 1'b1, 8, 128'h2, 1'b1};

    rst_n = 1'b0;
    cfg_algo_sel = 1'b0;
    cfg_key = '0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_eng_din", eng_din, 0);
    check("rst_eng_key", eng_key, 0);
    check("rst_eng_algo", eng_algo_sel, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    #1;
    check("idle_s_ready", s_ready, 1);

    // Single-block packets
    for (int i = 0; i < 5; i++) begin
      eng_lat = vecs[i].lat;
      send(vecs[i].algo, vecs[i].key, vecs[i].data, vecs[i].last);
      receive(vecs[i].exp_data, vecs[i].exp_last, 0);
    end
    check("starts_single", starts, 5);

    // Three-block packet: config changes after block 1 must be ignored
    eng_lat = 3;
    base = keys_seen.size();
    send(1'b0, AESK, AESD, 1'b0);
    receive(AESC, 1'b0, 0);
    send(1'b1, 128'hdeadbeef, 128'h10, 1'b0);
    receive(128'h10 ^ AESK, 1'b0, 0);
    send(1'b1, 128'hcafef00d, 128'h20, 1'b1);
    receive(128'h20 ^ AESK, 1'b1, 0);
    check("pkt_key0", keys_seen[base], AESK);
    check("pkt_key1", keys_seen[base+1], AESK);
    check("pkt_key2", keys_seen[base+2], AESK);

    // New packet picks up the new config again
    send(1'b1, 128'h0, 128'h0f, 1'b1);
    receive(128'hfffffffffffffffffffffffffffffff0, 1'b1, 0);

    // Output back-pressure for 20 cycles
    send(1'b0, 128'h5, 128'h6, 1'b1);
    receive(128'h3, 1'b1, 20);
    check("starts_total", starts, 10);
    check("operands_stable", op_err, 0);

`ifdef CRYPTO_TIMEOUT_EN
    // Result on the deadline cycle wins over the timeout
    eng_lat = 15;
    send(1'b0, 128'h1, 128'h2, 1'b1);
    receive(128'h3, 1'b1, 0);
    check("tie_no_err", err_timeout, 0);

    // Hung engine: abort on the 16th WAIT cycle
    eng_hang = 1;
    send(1'b0, 128'h1, 128'h7, 1'b1);
    n = 0;
    while (!m_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tmo_cycles", n, 17);
    check("tmo_err", err_timeout, 1);
    check("tmo_m_data", m_data, 0);
    check("tmo_m_last", m_last, 1);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_cnt++;
    m_ready = 1'b0;
    check("tmo_blk_cnt", blk_cnt, exp_cnt);
    eng_hang = 0;
    eng_lat = 3;
    send(1'b0, 128'h1, 128'h9, 1'b1);
    receive(128'h8, 1'b1, 0);
    check("tmo_sticky", err_timeout, 1);
`else
    check("err_tied_low", err_timeout, 0);
`endif

    // Reset during WAIT; the engine's later done must be ignored
    eng_lat = 6;
    send(1'b0, 128'h1, 128'h4, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    m_ready = 1'b1;
    ok = 1;
    st = 0;
    repeat (15) begin
      @(negedge clk);
      if (m_valid) ok = 0;
      if (eng_done) st++;
    end
    m_ready = 1'b0;
    check("stale_done_seen", st, 1);
    check("stale_no_m_valid", ok, 1);
    check("stale_blk_cnt", blk_cnt, 0);
    check("stale_m_data", m_data, 0);
    check("stale_idle", s_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
